// File: rtl/ram_to_tx_pkg.sv
// rtl/ram_to_tx_pkg.sv - shared text-overlay constants
package ram_to_tx_pkg;

    localparam int TXT_ADDR_W = 11;
    localparam int TXT_DATA_W = 8;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/ram_to_tx.sv
// rtl/ram_to_tx.sv - replays keyboard text RAM to a serial transmitter
module ram_to_tx
    import ram_to_tx_pkg::*;
#(
    parameter int ADDR_W  = TXT_ADDR_W,
    parameter int DATA_W  = TXT_DATA_W,
    parameter int RD_LAT  = 1,
    parameter bit CRLF_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              replay,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_en,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic [3:0]        led
);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        SEND,
        WAIT_HI,
        WAIT_LO,
        SEND_LF
    } state_t;

    // RD_WAIT counts up to RD_LAT; the capture happens on the edge after the last wait cycle
    localparam logic [1:0]        LAT_LAST = 2'(RD_LAT);
    localparam logic [DATA_W-1:0] CR_CHAR  = DATA_W'(ASCII_CR);
    localparam logic [DATA_W-1:0] LF_CHAR  = DATA_W'(ASCII_LF);

    state_t              state, state_d;
    logic [ADDR_W-1:0]   rd_ptr, rd_ptr_d;
    logic [ADDR_W-1:0]   ram_addr_d;
    logic                ram_en_d;
    logic [DATA_W-1:0]   tx_data_d;
    logic                tx_start_d;
    logic [DATA_W-1:0]   char_q, char_q_d;
    logic                lf_sent, lf_sent_d;
    logic [1:0]          lat_cnt, lat_cnt_d;

    // State register and all registered outputs; reset discards any character in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rd_ptr   <= '0;
            ram_addr <= '0;
            ram_en   <= 1'b0;
            tx_data  <= '0;
            tx_start <= 1'b0;
            char_q   <= '0;
            lf_sent  <= 1'b0;
            lat_cnt  <= '0;
            led      <= '0;
        end else begin
            state    <= state_d;
            rd_ptr   <= rd_ptr_d;
            ram_addr <= ram_addr_d;
            ram_en   <= ram_en_d;
            tx_data  <= tx_data_d;
            tx_start <= tx_start_d;
            char_q   <= char_q_d;
            lf_sent  <= lf_sent_d;
            lat_cnt  <= lat_cnt_d;
            led      <= rd_ptr_d[3:0];
        end
    end

    // Next-state and next-output logic; ram_en and tx_start default low so each is a one-cycle pulse
    always_comb begin
        state_d    = state;
        rd_ptr_d   = rd_ptr;
        ram_addr_d = ram_addr;
        ram_en_d   = 1'b0;
        tx_data_d  = tx_data;
        tx_start_d = 1'b0;
        char_q_d   = char_q;
        lf_sent_d  = lf_sent;
        lat_cnt_d  = lat_cnt;

        case (state)
            IDLE: begin
                // replay wins over a pending read; wr_addr is only looked at here
                if (replay) begin
                    rd_ptr_d = '0;
                end else if (rd_ptr != wr_addr) begin
                    rd_ptr_d   = rd_ptr + ADDR_W'(1);
                    ram_addr_d = rd_ptr + ADDR_W'(1);
                    ram_en_d   = 1'b1;
                    lat_cnt_d  = '0;
                    lf_sent_d  = 1'b0;
                    state_d    = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (lat_cnt == LAT_LAST) begin
                    char_q_d = ram_dout;
                    state_d  = SEND;
                end else begin
                    lat_cnt_d = lat_cnt + 2'd1;
                end
            end
            SEND: begin
                if (!tx_busy) begin
                    tx_data_d  = char_q;
                    tx_start_d = 1'b1;
                    state_d    = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (tx_busy) begin
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    if (CRLF_EN && (char_q == CR_CHAR) && !lf_sent) begin
                        state_d = SEND_LF;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            SEND_LF: begin
                char_q_d  = LF_CHAR;
                lf_sent_d = 1'b1;
                state_d   = SEND;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
